ddr3_frame_writer: RTL and testbench

- Write-side counterpart of the DDR3 read path that feeds the VGA data FIFO.
- Accepts a 32-bit pixel stream, packs four pixels into each 128-bit beat, and buffers the beats.
- Issues Avalon-MM burst writes to the DDR3 controller so a full IMAGE_WIDTH x IMAGE_HEIGHT frame lands at a programmable base address.
- Sits beside the read master in ddr3_top; start and base address come from the CSR block.

---
 rtl/ddr3_wr_pkg.sv | 21 ++
 rtl/ddr3_wr_fifo.sv | 68 ++++++
 rtl/ddr3_frame_writer.sv | 195 +++++++++++++++++++
 tb/tb_ddr3_frame_writer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_wr_pkg.sv
// Shared constants, state encoding and burst-sizing helper for the DDR3 frame writer.
package ddr3_wr_pkg;

  localparam int BEAT_W       = 128;
  localparam int PIX_W        = 32;
  localparam int PIX_PER_BEAT = 4;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    BURST,
    DONE
  } wr_state_e;

  // Size of the next burst: the configured maximum, or whatever is left of the frame.
  function automatic int unsigned min_burst(input int unsigned remaining,
                                            input int unsigned max_len);
    return (remaining < max_len) ? remaining : max_len;
  endfunction

endpackage

// File: rtl/ddr3_wr_fifo.sv
// First-word-fall-through beat FIFO with level output; depth need not be a power of two.
module ddr3_wr_fifo
  import ddr3_wr_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [BEAT_W-1:0] din,
  input  logic              pop,
  output logic [BEAT_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [LVL_W-1:0]  level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [BEAT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; empty/level gate every read of stale entries.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ddr3_frame_writer.sv
// Packs a 32-bit pixel stream into 128-bit beats and writes one frame to DDR3 via Avalon-MM bursts.
// Optional stall_count output is enabled with the macro DDR3_WR_STALL_CNT_EN.
module ddr3_frame_writer
  import ddr3_wr_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int BURST_LEN    = 8,
  parameter int ADDR_W       = 26
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              pix_ready,
  input  logic              ddr3_avl_ready,
  output logic              ddr3_avl_write_req,
  output logic              ddr3_avl_burstbegin,
  output logic [3:0]        ddr3_avl_size,
  output logic [ADDR_W-1:0] ddr3_avl_addr,
  output logic [BEAT_W-1:0] ddr3_avl_write_data,
  output logic [15:0]       ddr3_avl_be,
  output logic              busy,
`ifdef DDR3_WR_STALL_CNT_EN
  output logic [31:0]       stall_count,
`endif
  output logic              frame_done
);

  localparam int TOTAL_BEATS = IMAGE_WIDTH * IMAGE_HEIGHT / PIX_PER_BEAT;
  localparam int TOTAL_PIX   = TOTAL_BEATS * PIX_PER_BEAT;
  localparam int FIFO_DEPTH  = 2 * BURST_LEN;
  localparam int LVL_W       = $clog2(FIFO_DEPTH + 1);
  localparam int BEAT_CNT_W  = $clog2(TOTAL_BEATS + 1);
  localparam int PIX_CNT_W   = $clog2(TOTAL_PIX + 1);
  localparam int PACK_W      = PIX_W * (PIX_PER_BEAT - 1);

  wr_state_e              state_q, state_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic [BEAT_CNT_W-1:0]  beats_issued_q, beats_issued_d;
  logic [PIX_CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [PACK_W-1:0]      pack_q, pack_d;
  logic [1:0]             lane_q, lane_d;
  logic [3:0]             size_q, size_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   first_q, first_d;
  logic [3:0]             beat_cnt_q, beat_cnt_d;

  logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [BEAT_W-1:0]      fifo_dout;
  logic [LVL_W-1:0]       fifo_level;
  logic [BEAT_CNT_W-1:0]  remaining;
  logic [3:0]             burst;
  logic                   pix_fire, write_req, beat_acc;

  ddr3_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .din     ({pix_data, pack_q}),
    .pop     (fifo_pop),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Handshakes: a pixel transfers on pix_valid && pix_ready; a beat transfers on
  // write_req && ddr3_avl_ready. Neither side may retract or alter a pending offer.
  assign busy      = (state_q != IDLE);
  assign pix_ready = busy && !fifo_full && (pix_cnt_q < PIX_CNT_W'(TOTAL_PIX));
  assign pix_fire  = pix_valid && pix_ready;
  assign fifo_push = pix_fire && (lane_q == 2'd3);
  assign write_req = (state_q == BURST);
  assign beat_acc  = write_req && ddr3_avl_ready;
  assign fifo_pop  = beat_acc;
  assign remaining = BEAT_CNT_W'(TOTAL_BEATS) - beats_issued_q;
  assign burst     = 4'(min_burst(32'(remaining), 32'(BURST_LEN)));

  always_comb begin
    state_d        = state_q;
    wr_addr_d      = wr_addr_q;
    beats_issued_d = beats_issued_q;
    pix_cnt_d      = pix_cnt_q;
    pack_d         = pack_q;
    lane_d         = lane_q;
    size_d         = size_q;
    addr_d         = addr_q;
    first_d        = first_q;
    beat_cnt_d     = beat_cnt_q;

    // Shifting in from the top leaves the oldest pixel in the low lane once three are held.
    if (pix_fire) begin
      pix_cnt_d = pix_cnt_q + PIX_CNT_W'(1);
      lane_d    = lane_q + 2'd1;
      pack_d    = {pix_data, pack_q[PACK_W-1:PIX_W]};
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          wr_addr_d      = base_addr;
          beats_issued_d = '0;
          pix_cnt_d      = '0;
          lane_d         = '0;
          state_d        = FILL;
        end
      end
      FILL: begin
        if (32'(fifo_level) >= 32'(burst)) begin
          size_d     = burst;
          addr_d     = wr_addr_q;
          first_d    = 1'b1;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        if (beat_acc) begin
          first_d    = 1'b0;
          beat_cnt_d = beat_cnt_q + 4'd1;
          if (beat_cnt_q == size_q - 4'd1) begin
            wr_addr_d      = wr_addr_q + ADDR_W'(size_q);
            beats_issued_d = beats_issued_q + BEAT_CNT_W'(size_q);
            state_d        = (beats_issued_d == BEAT_CNT_W'(TOTAL_BEATS)) ? DONE : FILL;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      wr_addr_q      <= '0;
      beats_issued_q <= '0;
      pix_cnt_q      <= '0;
      pack_q         <= '0;
      lane_q         <= '0;
      size_q         <= '0;
      addr_q         <= '0;
      first_q        <= 1'b0;
      beat_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      wr_addr_q      <= wr_addr_d;
      beats_issued_q <= beats_issued_d;
      pix_cnt_q      <= pix_cnt_d;
      pack_q         <= pack_d;
      lane_q         <= lane_d;
      size_q         <= size_d;
      addr_q         <= addr_d;
      first_q        <= first_d;
      beat_cnt_q     <= beat_cnt_d;
    end
  end

  assign ddr3_avl_write_req  = write_req;
  assign ddr3_avl_burstbegin = write_req && first_q;
  assign ddr3_avl_size       = size_q;
  assign ddr3_avl_addr       = addr_q;
  assign ddr3_avl_write_data = (write_req && !fifo_empty) ? fifo_dout : '0;
  assign ddr3_avl_be         = 16'hFFFF;
  assign frame_done          = (state_q == DONE);

`ifdef DDR3_WR_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == IDLE && start) begin
      stall_cnt_d = '0;
    end else if (write_req && !ddr3_avl_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_cnt_q <= '0;
    else          stall_cnt_q <= stall_cnt_d;
  end

  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ddr3_frame_writer.sv
// Self-checking bench for ddr3_frame_writer: 10x10 frames against a burst/beat reference model.
module tb_ddr3_frame_writer;

  localparam int IMG_W     = 10;
  localparam int IMG_H     = 10;
  localparam int BURST_LEN = 8;
  localparam int ADDR_W    = 26;
  localparam int N_PIX     = IMG_W * IMG_H;
  localparam int N_BEATS   = N_PIX / 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              pix_valid = 1'b0;
  logic [31:0]       pix_data = '0;
  logic              pix_ready;
  logic              ddr3_avl_ready = 1'b1;
  logic              ddr3_avl_write_req;
  logic              ddr3_avl_burstbegin;
  logic [3:0]        ddr3_avl_size;
  logic [ADDR_W-1:0] ddr3_avl_addr;
  logic [127:0]      ddr3_avl_write_data;
  logic [15:0]       ddr3_avl_be;
  logic              busy;
  logic              frame_done;
`ifdef DDR3_WR_STALL_CNT_EN
  logic [31:0]       stall_count;
`endif

  ddr3_frame_writer #(
    .IMAGE_WIDTH  (IMG_W),
    .IMAGE_HEIGHT (IMG_H),
    .BURST_LEN    (BURST_LEN),
    .ADDR_W       (ADDR_W)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .start               (start),
    .base_addr           (base_addr),
    .pix_valid           (pix_valid),
    .pix_data            (pix_data),
    .pix_ready           (pix_ready),
    .ddr3_avl_ready      (ddr3_avl_ready),
    .ddr3_avl_write_req  (ddr3_avl_write_req),
    .ddr3_avl_burstbegin (ddr3_avl_burstbegin),
    .ddr3_avl_size       (ddr3_avl_size),
    .ddr3_avl_addr       (ddr3_avl_addr),
    .ddr3_avl_write_data (ddr3_avl_write_data),
    .ddr3_avl_be         (ddr3_avl_be),
    .busy                (busy),
`ifdef DDR3_WR_STALL_CNT_EN
    .stall_count         (stall_count),
`endif
    .frame_done          (frame_done)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard state
  logic [127:0]      exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [3:0]        exp_size_q[$];
  logic [31:0]       pix_mem[N_PIX];
  int                n_checks = 0;
  int                n_fail = 0;
  bit                mon_in_burst = 1'b0;
  logic [ADDR_W-1:0] cur_addr = '0;
  logic [3:0]        cur_size = '0;
  int                beat_in_burst = 0;
  int                bursts_seen = 0;
  int                beats_seen = 0;
  int                done_cnt = 0;
  int                stalls = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: beats are groups of four pixels, bursts tile the frame greedily.
  task automatic build_model(input logic [ADDR_W-1:0] base);
    int issued;
    int sz;
    exp_q.delete();
    exp_addr_q.delete();
    exp_size_q.delete();
    for (int b = 0; b < N_BEATS; b++)
      exp_q.push_back({pix_mem[4*b+3], pix_mem[4*b+2], pix_mem[4*b+1], pix_mem[4*b]});
    issued = 0;
    while (issued < N_BEATS) begin
      sz = (N_BEATS - issued < BURST_LEN) ? (N_BEATS - issued) : BURST_LEN;
      exp_addr_q.push_back(base + ADDR_W'(issued));
      exp_size_q.push_back(4'(sz));
      issued += sz;
    end
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_write_req"},  ddr3_avl_write_req,  0);
    chk({pfx, "_burstbegin"}, ddr3_avl_burstbegin, 0);
    chk({pfx, "_size"},       ddr3_avl_size,       0);
    chk({pfx, "_addr"},       ddr3_avl_addr,       0);
    chk({pfx, "_data"},       ddr3_avl_write_data, 0);
    chk({pfx, "_be"},         ddr3_avl_be,         16'hFFFF);
    chk({pfx, "_busy"},       busy,                0);
    chk({pfx, "_frame_done"}, frame_done,          0);
    chk({pfx, "_pix_ready"},  pix_ready,           0);
  endtask

  function automatic logic ready_for(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 2) == 0;
      2:       return cyc >= 80;
      default: return 1'(($urandom_range(0, 1)));
    endcase
  endfunction

  // Avalon monitor: every write_req cycle is checked against the expected burst and beat.
  always @(negedge clk) begin
    logic [127:0] dummy;
    if (reset_n) begin
      if (ddr3_avl_write_req) begin
        if (!mon_in_burst) begin
          chk("burst_expected", exp_addr_q.size() != 0, 1);
          if (exp_addr_q.size() != 0) begin
            cur_addr      = exp_addr_q.pop_front();
            cur_size      = exp_size_q.pop_front();
            mon_in_burst  = 1'b1;
            beat_in_burst = 0;
            bursts_seen++;
          end
        end
        if (mon_in_burst) begin
          chk("burstbegin", ddr3_avl_burstbegin, beat_in_burst == 0);
          chk("addr",       ddr3_avl_addr,       cur_addr);
          chk("size",       ddr3_avl_size,       cur_size);
          chk("be",         ddr3_avl_be,         16'hFFFF);
          chk("beat_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) chk("data", ddr3_avl_write_data, exp_q[0]);
          if (ddr3_avl_ready) begin
            if (exp_q.size() != 0) dummy = exp_q.pop_front();
            beat_in_burst++;
            beats_seen++;
            if (beat_in_burst == int'(cur_size)) mon_in_burst = 1'b0;
          end else begin
            stalls++;
          end
        end
      end
      if (frame_done) begin
        done_cnt++;
        chk("done_after_last_beat", exp_q.size(), 0);
      end
    end
  end

  // Driver: one frame with a chosen ready pattern, pixel pattern and disturbance.
  task automatic run_frame(input logic [ADDR_W-1:0] base, input int rmode, input bit incr,
                           input bit gaps, input int repulse_cyc, input bit reset_b2,
                           input string tag);
    int acc;
    int cyc;
    bit aborted;
    for (int i = 0; i < N_PIX; i++) pix_mem[i] = incr ? 32'(i) : $urandom;
    build_model(base);
    mon_in_burst = 1'b0;
    bursts_seen  = 0;
    beats_seen   = 0;
    done_cnt     = 0;
    stalls       = 0;
    acc          = 0;
    cyc          = 0;
    aborted      = 1'b0;

    @(posedge clk); #1;
    start          = 1'b1;
    base_addr      = base;
    pix_valid      = 1'b0;
    ddr3_avl_ready = ready_for(rmode, 0);
    @(posedge clk); #1;
    start     = 1'b0;
    base_addr = ADDR_W'($urandom);

    while (done_cnt == 0 && cyc < 4000 && !aborted) begin
      @(negedge clk);
      if (pix_valid && pix_ready) acc++;
      if (rmode == 2 && cyc == 79) begin
        chk({tag, "_pixels_buffered"}, acc, 64);
        chk({tag, "_pix_ready_full"}, pix_ready, 0);
      end
      if (reset_b2 && bursts_seen == 2 && mon_in_burst) begin
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs({tag, "_midreset"});
        exp_q.delete();
        exp_addr_q.delete();
        exp_size_q.delete();
        mon_in_burst = 1'b0;
        aborted      = 1'b1;
      end else begin
        @(posedge clk); #1;
        cyc++;
        ddr3_avl_ready = ready_for(rmode, cyc);
        pix_valid      = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        pix_data       = (acc < N_PIX) ? pix_mem[acc] : $urandom;
        start          = (cyc == repulse_cyc);
        if (cyc == repulse_cyc) base_addr = ADDR_W'(26'h500);
      end
    end

    if (aborted) begin
      @(posedge clk); #1;
      reset_n   = 1'b1;
      start     = 1'b0;
      pix_valid = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk({tag, "_no_done_after_abort"}, done_cnt, 0);
      chk({tag, "_idle_after_abort"}, busy, 0);
    end else begin
      chk({tag, "_frame_done_seen"}, done_cnt, 1);
      @(negedge clk);
      chk({tag, "_busy_dropped"}, busy, 0);
      chk({tag, "_done_one_cycle"}, frame_done, 0);
      pix_valid      = 1'b0;
      ddr3_avl_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk({tag, "_done_pulses"}, done_cnt, 1);
      chk({tag, "_beats"}, beats_seen, N_BEATS);
      chk({tag, "_bursts"}, bursts_seen, exp_size_q.size() + 4);
      chk({tag, "_pixels_accepted"}, acc, N_PIX);
      chk({tag, "_beats_left"}, exp_q.size(), 0);
`ifdef DDR3_WR_STALL_CNT_EN
      chk({tag, "_stall_count"}, stall_count, stalls);
`endif
    end
  endtask

  // Directed sequence
  initial begin
    reset_n        = 1'b0;
    ddr3_avl_ready = 1'b1;
    pix_valid      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_pix_ready", pix_ready, 0);
    chk("idle_busy", busy, 0);
    pix_valid = 1'b0;

    run_frame(26'h100,     0, 1'b1, 1'b0, -1, 1'b0, "t1_basic");
    run_frame(26'h100,     1, 1'b1, 1'b0, -1, 1'b0, "t2_toggle");
    run_frame(26'h100,     2, 1'b0, 1'b0, -1, 1'b0, "t3_backpressure");
    run_frame(26'h100,     3, 1'b0, 1'b1, 30, 1'b0, "t4_restart");
    run_frame(26'h100,     0, 1'b0, 1'b1, -1, 1'b1, "t5_reset");
    run_frame(26'h200,     0, 1'b0, 1'b1, -1, 1'b0, "t5_after_reset");
    run_frame(26'h3FFFFF8, 3, 1'b0, 1'b1, -1, 1'b0, "t6_wrap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
